// File: rtl/bytecode_fetch.sv
// Bytecode fetch stage: reads opcode and 0-2 immediate bytes from the class-area RAM,
// presents the assembled instruction via valid/ready, and owns the program counter.
module bytecode_fetch #(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        op_code,
  output logic [7:0]        arg1,
  output logic [7:0]        arg2,
  output logic [1:0]        argc,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target
);

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_OP    = 3'd1,
    S_ARG1  = 3'd2,
    S_ARG2  = 3'd3,
    S_VALID = 3'd4
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic [7:0]        op_q;
  logic [7:0]        arg1_q;
  logic [7:0]        arg2_q;
  logic [1:0]        argc_q;
  logic              valid_q;
  logic [ADDR_W-1:0] pc_d;
  logic [1:0]        op_len_d;

  function automatic logic [1:0] arg_len(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd0;
    if (op == 8'h10 || op == 8'h12 || op == 8'h15 || op == 8'h36)
      len = 2'd1;
    else if (op == 8'h11 || op == 8'h84 || (op >= 8'h99 && op <= 8'hA7))
      len = 2'd2;
    return len;
  endfunction

  assign op_len_d = arg_len(mem_data);
  assign pc_d     = pc_q + ADDR_W'(1) + ADDR_W'(argc_q);

  // The RAM registers the address, so each state requests the byte the next state consumes.
  always_comb begin
    mem_addr = pc_q;
    case (state_q)
      S_OP:    mem_addr = pc_q + ADDR_W'(1);
      S_ARG1:  mem_addr = pc_q + ADDR_W'(2);
      default: mem_addr = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      instr_pc_q <= '0;
      op_q       <= 8'h00;
      arg1_q     <= 8'h00;
      arg2_q     <= 8'h00;
      argc_q     <= 2'd0;
      valid_q    <= 1'b0;
    end else if (jump) begin
      state_q    <= S_REQ;
      pc_q       <= jump_target;
      instr_pc_q <= '0;
      op_q       <= 8'h00;
      arg1_q     <= 8'h00;
      arg2_q     <= 8'h00;
      argc_q     <= 2'd0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: state_q <= S_OP;
        S_OP: begin
          op_q       <= mem_data;
          instr_pc_q <= pc_q;
          argc_q     <= op_len_d;
          if (op_len_d == 2'd0) begin
            state_q <= S_VALID;
            valid_q <= 1'b1;
          end else begin
            state_q <= S_ARG1;
          end
        end
        S_ARG1: begin
          arg1_q <= mem_data;
          if (argc_q == 2'd1) begin
            state_q <= S_VALID;
            valid_q <= 1'b1;
          end else begin
            state_q <= S_ARG2;
          end
        end
        S_ARG2: begin
          arg2_q  <= mem_data;
          state_q <= S_VALID;
          valid_q <= 1'b1;
        end
        S_VALID: begin
          if (instr_ready) begin
            pc_q       <= pc_d;
            instr_pc_q <= '0;
            op_q       <= 8'h00;
            arg1_q     <= 8'h00;
            arg2_q     <= 8'h00;
            argc_q     <= 2'd0;
            valid_q    <= 1'b0;
            state_q    <= S_REQ;
          end
        end
        default: begin
          state_q <= S_REQ;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Control idles on 8'h00, so the opcode is masked until the instruction is complete.
  assign op_code     = valid_q ? op_q : 8'h00;
  assign arg1        = arg1_q;
  assign arg2        = arg2_q;
  assign argc        = argc_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_bytecode_fetch.sv
// Bench for bytecode_fetch: vector table, directed corner sequences, and a randomized
// run scored against a transaction-level model of the program stream.
module tb_bytecode_fetch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic [7:0] op_code, arg1, arg2;
  logic [1:0] argc;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       jump = 1'b0;
  logic [7:0] jump_target = 8'h00;

  logic [7:0] mem [256];

  int errors = 0;
  int checks = 0;

  bytecode_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data(mem_data),
    .op_code(op_code), .arg1(arg1), .arg2(arg2), .argc(argc),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .jump(jump), .jump_target(jump_target)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[mem_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference argument-length table, expressed as set membership.
  function automatic int ref_len(input logic [7:0] op);
    if (op inside {8'h10, 8'h12, 8'h15, 8'h36}) return 1;
    if (op inside {8'h11, 8'h84, [8'h99:8'hA7]}) return 2;
    return 0;
  endfunction

  // Expected {op, arg1, arg2, argc, pc} of the instruction starting at pc.
  function automatic logic [39:0] ref_instr(input logic [7:0] pc);
    int n;
    logic [7:0] a1, a2, p1, p2;
    n  = ref_len(mem[pc]);
    p1 = pc + 8'd1;
    p2 = pc + 8'd2;
    a1 = (n >= 1) ? mem[p1] : 8'h00;
    a2 = (n >= 2) ? mem[p2] : 8'h00;
    return {mem[pc], a1, a2, 8'(n), pc};
  endfunction

  function automatic logic [39:0] dut_instr();
    return {op_code, arg1, arg2, 6'd0, argc, instr_pc};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    instr_ready = 1'b0;
    jump = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!instr_valid && n < 30);
    if (!instr_valid) chk("valid_timeout", 64'(instr_valid), 64'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic [7:0] e_op, e_a1, e_a2;
    logic [1:0] e_argc;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int n;
    int accepted;
    logic [7:0] mpc;
    logic [39:0] exp_i;
    logic stable;
    logic saw_bad;
    logic [7:0] ops [8];

    vecs[0] = '{8'h04, 8'h05, 8'h60, 8'h04, 8'h00, 8'h00, 2'd0};
    vecs[1] = '{8'h11, 8'h01, 8'h2C, 8'h11, 8'h01, 8'h2C, 2'd2};
    vecs[2] = '{8'h10, 8'h7F, 8'h00, 8'h10, 8'h7F, 8'h00, 2'd1};
    vecs[3] = '{8'h36, 8'hAA, 8'hBB, 8'h36, 8'hAA, 8'h00, 2'd1};
    vecs[4] = '{8'hA7, 8'h12, 8'h34, 8'hA7, 8'h12, 8'h34, 2'd2};
    vecs[5] = '{8'h99, 8'h56, 8'h78, 8'h99, 8'h56, 8'h78, 2'd2};
    vecs[6] = '{8'h98, 8'h11, 8'h22, 8'h98, 8'h00, 8'h00, 2'd0};
    vecs[7] = '{8'hA8, 8'h33, 8'h44, 8'hA8, 8'h00, 8'h00, 2'd0};
    vecs[8] = '{8'h00, 8'h55, 8'h66, 8'h00, 8'h00, 8'h00, 2'd0};
    vecs[9] = '{8'h84, 8'hFE, 8'hED, 8'h84, 8'hFE, 8'hED, 2'd2};

    clear_mem();
    rst = 1'b1;
    #3;
    chk("reset_valid", 64'(instr_valid), 64'd0);
    chk("reset_fields", {op_code, arg1, arg2, 6'd0, argc, instr_pc}, 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);

    // Table: single instruction at pc 0, latency, fields, and the pc after acceptance.
    for (int v = 0; v < 10; v++) begin
      clear_mem();
      mem[0] = vecs[v].b0; mem[1] = vecs[v].b1; mem[2] = vecs[v].b2;
      do_reset();
      wait_valid(n);
      chk($sformatf("vec%0d_latency", v), 64'(n), 64'(2 + vecs[v].e_argc));
      chk($sformatf("vec%0d_fields", v), 64'(dut_instr()),
          64'({vecs[v].e_op, vecs[v].e_a1, vecs[v].e_a2, 6'd0, vecs[v].e_argc, 8'h00}));
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      chk($sformatf("vec%0d_drop_op", v), {instr_valid, op_code}, 64'd0);
      wait_valid(n);
      chk($sformatf("vec%0d_next_pc", v), 64'(instr_pc), 64'(1 + vecs[v].e_argc));
    end

    // Three argc=0 instructions back to back with ready tied high.
    clear_mem();
    mem[0] = 8'h04; mem[1] = 8'h05; mem[2] = 8'h60;
    do_reset();
    instr_ready = 1'b1;
    wait_valid(n);
    chk("b2b_first_latency", 64'(n), 64'd2);
    chk("b2b_i0", {op_code, instr_pc}, {8'h04, 8'h00});
    wait_valid(n);
    chk("b2b_gap1", 64'(n), 64'd3);
    chk("b2b_i1", {op_code, instr_pc}, {8'h05, 8'h01});
    wait_valid(n);
    chk("b2b_gap2", 64'(n), 64'd3);
    chk("b2b_i2", {op_code, instr_pc}, {8'h60, 8'h02});
    instr_ready = 1'b0;

    // Ready held low: instruction must stay put until accepted.
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h7F;
    do_reset();
    wait_valid(n);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!instr_valid || dut_instr() !== {8'h10, 8'h7F, 8'h00, 8'd1, 8'h00}) stable = 1'b0;
    end
    chk("hold_stable", 64'(stable), 64'd1);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("hold_release", 64'(instr_valid), 64'd0);
    wait_valid(n);
    chk("hold_next_pc", 64'(instr_pc), 64'h02);

    // Jump during ARG1 of a two-byte instruction at pc 5.
    clear_mem();
    mem[5] = 8'h84; mem[6] = 8'h01; mem[7] = 8'h02;
    mem[8'h40] = 8'h12; mem[8'h41] = 8'h55;
    do_reset();
    jump = 1'b1; jump_target = 8'h05;
    step();
    jump = 1'b0;
    saw_bad = 1'b0;
    step();
    step();
    if (instr_valid) saw_bad = 1'b1;
    jump = 1'b1; jump_target = 8'h40;
    step();
    jump = 1'b0;
    if (instr_valid) saw_bad = 1'b1;
    wait_valid(n);
    chk("jarg1_no_present", 64'(saw_bad), 64'd0);
    chk("jarg1_target", {op_code, arg1, instr_pc}, {8'h12, 8'h55, 8'h40});

    // Jump and ready together in VALID: jump wins.
    clear_mem();
    mem[8'h10] = 8'h00; mem[8'h11] = 8'h05; mem[8'h20] = 8'h06;
    do_reset();
    jump = 1'b1; jump_target = 8'h10;
    step();
    jump = 1'b0;
    wait_valid(n);
    chk("jrdy_held_pc", 64'(instr_pc), 64'h10);
    instr_ready = 1'b1; jump = 1'b1; jump_target = 8'h20;
    step();
    jump = 1'b0;
    chk("jrdy_drop", 64'(instr_valid), 64'd0);
    wait_valid(n);
    chk("jrdy_target", {op_code, instr_pc}, {8'h06, 8'h20});
    instr_ready = 1'b0;

    // Instruction straddling the top of memory.
    clear_mem();
    mem[8'hFF] = 8'h10; mem[0] = 8'h33; mem[1] = 8'h07;
    do_reset();
    jump = 1'b1; jump_target = 8'hFF;
    step();
    jump = 1'b0;
    wait_valid(n);
    chk("wrap_fields", 64'(dut_instr()), 64'({8'h10, 8'h33, 8'h00, 8'd1, 8'hFF}));
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    wait_valid(n);
    chk("wrap_next_pc", {op_code, instr_pc}, {8'h07, 8'h01});

    // Asynchronous reset in ARG2 of an instruction at pc 0x30.
    clear_mem();
    mem[8'h30] = 8'h84; mem[8'h31] = 8'hAB; mem[8'h32] = 8'hCD;
    mem[0] = 8'h11; mem[1] = 8'h01; mem[2] = 8'h2C;
    do_reset();
    jump = 1'b1; jump_target = 8'h30;
    step();
    jump = 1'b0;
    step();
    step();
    step();
    chk("arst_pre", {instr_valid, argc, instr_pc}, {1'b0, 2'd2, 8'h30});
    #2;
    rst = 1'b1;
    #1;
    chk("arst_clear", {instr_valid, op_code, argc, instr_pc, mem_addr}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_valid(n);
    chk("arst_restart", {op_code, arg1, arg2, instr_pc}, {8'h11, 8'h01, 8'h2C, 8'h00});

    // Randomized run against the program-stream model.
    ops = '{8'h10, 8'h12, 8'h15, 8'h36, 8'h11, 8'h84, 8'h99, 8'hA7};
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom % 3 == 0) ? ops[$urandom % 8] : 8'($urandom);
    do_reset();
    mpc = 8'h00;
    accepted = 0;
    for (int c = 0; c < 3000; c++) begin
      if (instr_valid) begin
        exp_i = ref_instr(mpc);
        chk("rand_instr", 64'(dut_instr()), 64'(exp_i));
      end else begin
        chk("rand_idle_op", 64'(op_code), 64'd0);
      end
      instr_ready = ($urandom % 2) == 0;
      jump = ($urandom % 20) == 0;
      jump_target = 8'($urandom);
      if (jump) mpc = jump_target;
      else if (instr_valid && instr_ready) begin
        mpc = mpc + 8'(1 + ref_len(mem[mpc]));
        accepted++;
      end
      step();
    end
    instr_ready = 1'b0;
    jump = 1'b0;
    chk("rand_progress", 64'(accepted > 100), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
